fetch_queue_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the memory manager's IF port.
- Owns the program counter and drives the fetch address to the memory manager each cycle.
- Captures the returned instruction word together with its PC into a small instruction queue, which feeds decode via a valid/ready handshake.
- Holds the PC and discards the returned word in any cycle where the MEM stage owns RAM, since the manager returns NOP to IF in that cycle.
- Handles branch/jump redirects by flushing the queue.

---
 rtl/fetch_queue_stage_pkg.sv | 9 +
 rtl/fetch_queue_stage_chk.sv | 15 +
 rtl/fetch_queue_stage_inst_queue.sv | 92 +++++++++
 rtl/fetch_queue_stage.sv | 87 ++++++++
 tb/tb_fetch_queue_stage.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_stage_pkg.sv
// Shared widths and constants for the instruction-fetch stage.
// Mirrors the memory manager's RAMREAD_WIDTH, RAMADDR_WIDTH and CONST_NOP values.
package fetch_queue_stage_pkg;

    localparam int RAMREAD_WIDTH = 16;
    localparam int RAMADDR_WIDTH = 16;
    localparam logic [RAMREAD_WIDTH-1:0] CONST_NOP = 16'h0000;

endpackage

// File: rtl/fetch_queue_stage_chk.sv
// Invariant checker for the instruction queue occupancy.
module fetch_queue_stage_chk #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             reset,
    input logic [CNT_W-1:0] count
);

    // Occupancy must never exceed the queue depth.
    a_count_bound : assert property (@(posedge clk) disable iff (reset)
        count <= CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue_stage_inst_queue.sv
// Small synchronous FIFO holding {pc, instruction} pairs for decode.
// Flush empties the queue and takes priority over a push in the same cycle.
module inst_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; writes are dropped while flushing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == CNT_W'(0));
    assign full_o  = (count_q == CNT_W'(DEPTH));

    fetch_queue_stage_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .count (count_q)
    );

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: owns the PC, fetches through the memory manager's IF port
// and buffers fetched words for decode; yields RAM to MEM reads and flushes on redirect.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int                DATA_W   = RAMREAD_WIDTH,
    parameter int                ADDR_W   = RAMADDR_WIDTH,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_req,
    output logic [ADDR_W-1:0] if_addr,
    input  logic [DATA_W-1:0] if_read,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              fetch_stall
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     fetch_stall_q, fetch_stall_d;
    logic                     pop_s;
    logic                     fetch_ok_s;
    logic [ADDR_W+DATA_W-1:0] head_s;
    logic [CNT_W-1:0]         count_s;
    logic                     empty_s;
    logic                     full_s;

    assign pop_s = dec_valid & dec_ready;
    // A full queue can still accept a push when decode frees the head this cycle.
    assign fetch_ok_s = !redirect && !halt && !mem_read_req && (!full_s || pop_s);

    // PC and stall-flag next state; redirect wins over a normal fetch.
    always_comb begin
        pc_d          = pc_q;
        fetch_stall_d = !redirect && !halt && !fetch_ok_s;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (fetch_ok_s) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC and stall-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            fetch_stall_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_stall_q <= fetch_stall_d;
        end
    end

    inst_queue #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_inst_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fetch_ok_s),
        .pop_i   (pop_s),
        .flush_i (redirect),
        .data_i  ({pc_q, if_read}),
        .head_o  (head_s),
        .count_o (count_s),
        .empty_o (empty_s),
        .full_o  (full_s)
    );

    assign if_addr     = pc_q;
    assign dec_valid   = !empty_s;
    assign dec_instr   = empty_s ? DATA_W'(CONST_NOP) : head_s[DATA_W-1:0];
    assign dec_pc      = empty_s ? ADDR_W'(0) : head_s[ADDR_W+DATA_W-1:DATA_W];
    assign fetch_stall = fetch_stall_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed self-checking bench for fetch_queue_stage with a combinational RAM model.
module tb_fetch_queue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_req;
    logic [15:0] if_addr;
    logic [15:0] if_read;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic        fetch_stall;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] NOP = 16'h0000;

    // RAM contents: nibble (addr[3:0]+1) repeated, high address byte xor'd in.
    function automatic logic [15:0] ram_word(input logic [15:0] a);
        logic [3:0] n;
        n = a[3:0] + 4'd1;
        return {n, n, n, n} ^ {a[15:8], 8'h00};
    endfunction

    assign if_read = mem_read_req ? NOP : ram_word(if_addr);

    always #5 clk = ~clk;

    fetch_queue_stage dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read_req (mem_read_req),
        .if_addr      (if_addr),
        .if_read      (if_read),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_instr    (dec_instr),
        .dec_pc       (dec_pc),
        .fetch_stall  (fetch_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_read_req = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        halt = 1'b0; dec_ready = 1'b1;
        #1;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dec_valid); end
        checks++; if (dec_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", dec_instr, NOP); end
        checks++; if (dec_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h exp 0000", dec_pc); end
        checks++; if (if_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h exp 0000", if_addr); end
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", fetch_stall); end
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (if_addr !== 16'h0000) begin errors++; $display("FAIL release_addr got %h exp 0000", if_addr); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (if_addr !== 16'(k + 1)) begin errors++; $display("FAIL stream_addr[%0d] got %h exp %h", k, if_addr, 16'(k + 1)); end
            checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", k, dec_valid); end
            checks++; if (dec_pc !== 16'(k)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", k, dec_pc, 16'(k)); end
            checks++; if (dec_instr !== 16'h1111 * 16'(k + 1)) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", k, dec_instr, 16'h1111 * 16'(k + 1)); end
        end
    endtask

    task automatic test_mem_stall();
        tick();
        checks++; if (if_addr !== 16'h0005) begin errors++; $display("FAIL memst_pre_addr got %h exp 0005", if_addr); end
        mem_read_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (if_addr !== 16'h0005) begin errors++; $display("FAIL memst_addr[%0d] got %h exp 0005", k, if_addr); end
            checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL memst_stall[%0d] got %b exp 1", k, fetch_stall); end
            checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL memst_nop_enq[%0d] got %b exp 0", k, dec_valid); end
        end
        mem_read_req = 1'b0;
        tick();
        checks++; if (if_addr !== 16'h0006) begin errors++; $display("FAIL memst_resume_addr got %h exp 0006", if_addr); end
        checks++; if (dec_pc !== 16'h0005) begin errors++; $display("FAIL memst_resume_pc got %h exp 0005", dec_pc); end
        checks++; if (dec_instr !== 16'h6666) begin errors++; $display("FAIL memst_resume_instr got %h exp 6666", dec_instr); end
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL memst_resume_stall got %b exp 0", fetch_stall); end
    endtask

    task automatic test_backpressure();
        dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (if_addr !== 16'h0007) begin errors++; $display("FAIL bp_addr[%0d] got %h exp 0007", k, if_addr); end
            checks++; if (dec_pc !== 16'h0005 || dec_instr !== 16'h6666) begin errors++; $display("FAIL bp_head[%0d] got %h/%h exp 0005/6666", k, dec_pc, dec_instr); end
        end
        checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL bp_stall got %b exp 1", fetch_stall); end
        dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (dec_pc !== 16'(k + 6)) begin errors++; $display("FAIL drain_pc[%0d] got %h exp %h", k, dec_pc, 16'(k + 6)); end
            checks++; if (dec_instr !== 16'h1111 * 16'(k + 7)) begin errors++; $display("FAIL drain_instr[%0d] got %h exp %h", k, dec_instr, 16'h1111 * 16'(k + 7)); end
            checks++; if (if_addr !== 16'(k + 8)) begin errors++; $display("FAIL drain_addr[%0d] got %h exp %h", k, if_addr, 16'(k + 8)); end
        end
    endtask

    task automatic test_redirect();
        dec_ready = 1'b0;
        tick();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0008) begin errors++; $display("FAIL redir_pre got %b/%h exp 1/0008", dec_valid, dec_pc); end
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", dec_valid); end
        checks++; if (if_addr !== 16'h0040) begin errors++; $display("FAIL redir_addr got %h exp 0040", if_addr); end
        checks++; if (dec_instr !== NOP || dec_pc !== 16'h0000) begin errors++; $display("FAIL redir_empty got %h/%h exp %h/0000", dec_instr, dec_pc, NOP); end
        redirect = 1'b0; dec_ready = 1'b1;
        tick();
        checks++; if (dec_pc !== 16'h0040 || dec_instr !== 16'h1111) begin errors++; $display("FAIL redir_target got %h/%h exp 0040/1111", dec_pc, dec_instr); end
    endtask

    task automatic test_halt_wrap();
        halt = 1'b1;
        tick();
        checks++; if (dec_valid !== 1'b0 || if_addr !== 16'h0041) begin errors++; $display("FAIL halt_hold got %b/%h exp 0/0041", dec_valid, if_addr); end
        checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL halt_stall got %b exp 0", fetch_stall); end
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        checks++; if (if_addr !== 16'hFFFF) begin errors++; $display("FAIL halt_redir_addr got %h exp ffff", if_addr); end
        redirect = 1'b0; halt = 1'b0;
        tick();
        checks++; if (if_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr got %h exp 0000", if_addr); end
        checks++; if (dec_pc !== 16'hFFFF || dec_instr !== 16'hFF00) begin errors++; $display("FAIL wrap_head got %h/%h exp ffff/ff00", dec_pc, dec_instr); end
    endtask

    task automatic test_reset_midstream();
        dec_ready = 1'b0;
        tick();
        checks++; if (if_addr !== 16'h0001 || dec_valid !== 1'b1) begin errors++; $display("FAIL full_pre got %h/%b exp 0001/1", if_addr, dec_valid); end
        reset = 1'b1;
        #1;
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", dec_valid); end
        checks++; if (dec_instr !== NOP) begin errors++; $display("FAIL async_instr got %h exp %h", dec_instr, NOP); end
        checks++; if (if_addr !== 16'h0000) begin errors++; $display("FAIL async_addr got %h exp 0000", if_addr); end
        @(negedge clk);
        reset = 1'b0; dec_ready = 1'b1;
        tick();
        checks++; if (dec_pc !== 16'h0000 || dec_instr !== 16'h1111) begin errors++; $display("FAIL post_reset got %h/%h exp 0000/1111", dec_pc, dec_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_mem_stall();
        test_backpressure();
        test_redirect();
        test_halt_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
